// File: rtl/encoder_8_to_3_scan_if.sv
// Request/code handshake bundle for the sequential 8-to-3 priority encoder.
// Latency: none, wires only.
// Backpressure: READY from the consumer; VALID/CODE from the encoder.
//
// Signals:
//   G      enable; low pauses scanning
//   LOAD   request to capture IN (only honoured in IDLE with G=1)
//   IN     8-bit request vector, bit i requests code i
//   READY  consumer takes CODE this cycle
//   CODE   index of current highest-priority pending bit
//   VALID  CODE is valid
//   BUSY   encoder is scanning (LOAD ignored)
//   DONE   one-cycle pulse, all captured bits emitted
//   EMPTY  one-cycle pulse, LOAD accepted with IN == 0
interface encoder_8_to_3_scan_if;
    logic       G;
    logic       LOAD;
    logic [7:0] IN;
    logic       READY;
    logic [2:0] CODE;
    logic       VALID;
    logic       BUSY;
    logic       DONE;
    logic       EMPTY;

    // Encoder side.
    modport slave (
        input  G, LOAD, IN, READY,
        output CODE, VALID, BUSY, DONE, EMPTY
    );

    // Requester / consumer side.
    modport master (
        output G, LOAD, IN, READY,
        input  CODE, VALID, BUSY, DONE, EMPTY
    );
endinterface

// File: rtl/encoder_8_to_3_scan.sv
// Serialises a multi-hot 8-bit request word into 3-bit indices, one per handshake.
// Latency: LOAD accepted at edge t gives VALID and the first CODE from t+1; one code/cycle.
// Backpressure: READY=0 holds CODE and pending; G=0 freezes scanning and drops VALID.
//
// Ports:
//   CLK      rising-edge clock
//   RESET_N  synchronous active-low reset
//   bus      encoder_8_to_3_scan_if.slave (G, LOAD, IN, READY in; CODE, VALID,
//            BUSY, DONE, EMPTY out)
module encoder_8_to_3_scan #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    encoder_8_to_3_scan_if.slave        bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0] state_q,   state_d;
    logic [7:0] pending_q, pending_d;
    logic       done_q,    done_d;
    logic       empty_q,   empty_d;

    logic [2:0] code;
    logic [7:0] clr_mask;
    logic [7:0] pending_clr;
    logic       valid;
    logic       xfer;

    // Priority index of the pending word. The last match in the loop wins,
    // so the scan direction sets the priority. Pending == 0 yields 0.
    always_comb begin
        code = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) code = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) code = 3'(i);
            end
        end
    end

    assign clr_mask    = 8'b1 << code;
    assign pending_clr = pending_q & ~clr_mask;
    assign valid       = (state_q == ST_SCAN) && bus.G;
    assign xfer        = valid && bus.READY;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        empty_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.G && bus.LOAD) begin
                    if (bus.IN != 8'h00) begin
                        pending_d = bus.IN;
                        state_d   = ST_SCAN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // LOAD is ignored here; only a transfer changes pending.
                if (xfer) begin
                    pending_d = pending_clr;
                    if (pending_clr == 8'h00) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            pending_q <= 8'h00;
            done_q    <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            empty_q   <= empty_d;
        end
    end

    assign bus.CODE  = code;
    assign bus.VALID = valid;
    assign bus.BUSY  = (state_q == ST_SCAN);
    assign bus.DONE  = done_q;
    assign bus.EMPTY = empty_q;

endmodule

// File: tb/tb_encoder_8_to_3_scan.sv
// Self-checking bench: both priority orders run side by side on identical stimulus.
// Latency: expected code order is derived from the set bits of each loaded word.
// Backpressure: G/READY are directed or randomised; pops happen only on VALID&READY.
module tb_encoder_8_to_3_scan;

    logic CLK;
    logic RESET_N;

    encoder_8_to_3_scan_if bus_hi ();
    encoder_8_to_3_scan_if bus_lo ();

    encoder_8_to_3_scan #(.HIGH_FIRST(1'b1)) dut_hi (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_hi.slave)
    );

    encoder_8_to_3_scan #(.HIGH_FIRST(1'b0)) dut_lo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_lo.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic g, input logic load, input logic [7:0] in_v,
                         input logic rdy);
        bus_hi.G = g;  bus_hi.LOAD = load;  bus_hi.IN = in_v;  bus_hi.READY = rdy;
        bus_lo.G = g;  bus_lo.LOAD = load;  bus_lo.IN = in_v;  bus_lo.READY = rdy;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Checks all status outputs of both instances against one expectation.
    task automatic chk_status(input string tag, input logic valid, input logic busy,
                              input logic done, input logic empty);
        chk({tag, "_valid_hi"}, {7'd0, bus_hi.VALID}, {7'd0, valid});
        chk({tag, "_valid_lo"}, {7'd0, bus_lo.VALID}, {7'd0, valid});
        chk({tag, "_busy_hi"},  {7'd0, bus_hi.BUSY},  {7'd0, busy});
        chk({tag, "_busy_lo"},  {7'd0, bus_lo.BUSY},  {7'd0, busy});
        chk({tag, "_done_hi"},  {7'd0, bus_hi.DONE},  {7'd0, done});
        chk({tag, "_done_lo"},  {7'd0, bus_lo.DONE},  {7'd0, done});
        chk({tag, "_empty_hi"}, {7'd0, bus_hi.EMPTY}, {7'd0, empty});
        chk({tag, "_empty_lo"}, {7'd0, bus_lo.EMPTY}, {7'd0, empty});
    endtask

    // Loads v from IDLE (or a DONE cycle) and follows the scan to its end.
    // mode 0: G=1, READY=1 throughout
    // mode 1: random G and READY every cycle
    // mode 2: READY low 3 cycles, then G low 2 cycles, then free-running
    // mode 3: G=1, READY=1, LOAD with IN=8'h55 asserted during the scan
    task automatic do_load(input string tag, input logic [7:0] v, input int mode);
        logic [2:0] qh[$];
        logic [2:0] ql[$];
        int   guard;
        logic g, rdy;
        for (int i = 7; i >= 0; i--) if (v[i]) qh.push_back(3'(i));
        for (int i = 0; i < 8; i++)  if (v[i]) ql.push_back(3'(i));

        drive(1'b1, 1'b1, v, 1'b1);
        #1;
        chk({tag, "_pre_busy"}, {7'd0, bus_hi.BUSY}, 8'd0);
        cyc();

        if (v == 8'h00) begin
            drive(1'b1, 1'b0, 8'($urandom), 1'b1);
            #1;
            chk_status({tag, "_empty"}, 1'b0, 1'b0, 1'b0, 1'b1);
            return;
        end

        guard = 0;
        while (qh.size() > 0 && guard < 300) begin
            case (mode)
                1:       begin g = ($urandom_range(0, 3) != 0); rdy = $urandom_range(0, 1) == 1; end
                2:       begin g = !(guard == 3 || guard == 4); rdy = (guard >= 5); end
                default: begin g = 1'b1; rdy = 1'b1; end
            endcase
            // IN is scrambled to show it has no path to CODE after capture.
            if (mode == 3) drive(g, 1'b1, 8'h55, rdy);
            else           drive(g, 1'b0, 8'($urandom), rdy);
            #1;
            chk_status({tag, "_scan"}, g, 1'b1, 1'b0, 1'b0);
            chk({tag, "_code_hi"}, {5'd0, bus_hi.CODE}, {5'd0, qh[0]});
            chk({tag, "_code_lo"}, {5'd0, bus_lo.CODE}, {5'd0, ql[0]});
            cyc();
            if (g && rdy) begin
                void'(qh.pop_front());
                void'(ql.pop_front());
            end
            guard++;
        end
        if (guard >= 300) begin
            n_asrt++;
            n_fail++;
            $error("FAIL %s_timeout observed=%0d expected<300", tag, guard);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        chk_status({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] rv;
        RESET_N = 1'b0;
        drive(1'b1, 1'b1, 8'hFF, 1'b1);

        // Reset overrides LOAD for two edges.
        cyc();
        cyc();
        chk_status("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_code_hi", {5'd0, bus_hi.CODE}, 8'd0);
        chk("rst_code_lo", {5'd0, bus_lo.CODE}, 8'd0);
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        chk_status("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_rel_code", {5'd0, bus_hi.CODE}, 8'd0);

        // Full-throughput scan; DONE lands on the 5th cycle after the LOAD edge.
        do_load("a6", 8'b1010_0110, 0);

        // Back-to-back load accepted in the DONE cycle.
        do_load("b2b", 8'h3C, 0);

        // Backpressure then pause.
        do_load("bp81", 8'h81, 2);

        // LOAD with G=0 in IDLE is ignored.
        drive(1'b0, 1'b1, 8'hAA, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        chk_status("g0_load", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Zero load: EMPTY pulse only, then it clears.
        do_load("zero", 8'h00, 0);
        cyc();
        chk_status("zero_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // LOAD during scan is ignored.
        do_load("ign55", 8'h03, 3);

        // Reset mid-scan discards pending without DONE.
        drive(1'b1, 1'b1, 8'hF0, 1'b1);
        cyc();
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        #1;
        chk("mid_code_hi", {5'd0, bus_hi.CODE}, 8'd7);
        chk("mid_code_lo", {5'd0, bus_lo.CODE}, 8'd4);
        cyc();
        RESET_N = 1'b0;
        cyc();
        RESET_N = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        chk_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_code", {5'd0, bus_hi.CODE}, 8'd0);
        cyc();
        chk_status("mid_rst2", 1'b0, 1'b0, 1'b0, 1'b0);
        do_load("after_rst", 8'h08, 0);

        // Randomised loads with random G/READY.
        for (int k = 0; k < 40; k++) begin
            rv = 8'($urandom);
            if (k == 0) rv = 8'hFF;
            do_load("rnd", rv, 1);
            if ($urandom_range(0, 1) == 1) cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
